// File: rtl/sifh_pkg.sv
// Shared definitions for the SiFH histogram engine.
//  state_t  : engine FSM encoding
//  clog2    : ceiling log2 usable in parameter expressions
//  pix_w    : pixel index width, never below 1
//  sat_inc  : saturating increment for a w-bit counter
package sifh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACQ   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_PEAK  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned pix_w(input int unsigned pixels);
    return (pixels <= 1) ? 1 : clog2(pixels);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sifh_peak_tracker.sv
// Running maximum / argmax over one pixel's bin stream.
//  clk, res            : clock, async active-low reset
//  clear               : drop running max and zero the result outputs
//  sample              : data/bin valid this cycle
//  emit                : this sample is the pixel's last bin; publish result
//  data, bin, pix      : sampled count, its bin, and the pixel being scanned
//  peak_valid          : one-cycle pulse with the published result
//  peak_pix/bin/count  : published result, held until the next emit/clear
module sifh_peak_tracker #(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned PIX_W  = 2,
  parameter int unsigned PEAK_W = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              clear,
  input  logic              sample,
  input  logic              emit,
  input  logic [PEAK_W-1:0] data,
  input  logic [BIN_W-1:0]  bin,
  input  logic [PIX_W-1:0]  pix,
  output logic              peak_valid,
  output logic [PIX_W-1:0]  peak_pix,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [PEAK_W-1:0] peak_count
);

  logic [PEAK_W-1:0] max_q;
  logic [BIN_W-1:0]  arg_q;
  logic              greater;
  logic [PEAK_W-1:0] cand_count;
  logic [BIN_W-1:0]  cand_bin;

  // Strict compare keeps the lowest bin on ties; max starts at 0 so an
  // empty histogram reports bin 0, count 0.
  always_comb begin
    greater    = sample && (data > max_q);
    cand_count = greater ? data : max_q;
    cand_bin   = greater ? bin  : arg_q;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      max_q      <= '0;
      arg_q      <= '0;
      peak_valid <= 1'b0;
      peak_pix   <= '0;
      peak_bin   <= '0;
      peak_count <= '0;
    end else begin
      // Emit also restarts the tracker so the next pixel's bin 0 can be
      // sampled in the very next cycle.
      if (clear || emit) begin
        max_q <= '0;
        arg_q <= '0;
      end else if (greater) begin
        max_q <= data;
        arg_q <= bin;
      end
      peak_valid <= emit;
      if (emit) begin
        peak_pix   <= pix;
        peak_bin   <= cand_bin;
        peak_count <= cand_count;
      end else if (clear) begin
        peak_pix   <= '0;
        peak_bin   <= '0;
        peak_count <= '0;
      end
    end
  end

endmodule

// File: rtl/sifh_hist_engine.sv
// Multi-pixel SPAD dToF histogram engine over an external 1R1W RAM.
//  clk, res                 : clock, async active-low reset
//  start, laser_sync        : frame start pulse, acquisition-end pulse
//  ts_valid/ts_ready        : timestamp handshake (ready only while acquiring)
//  ts_data, ts_pix          : timestamp and source pixel
//  ram_raddr/re/rdata       : RAM read port, data valid one cycle after re
//  ram_waddr/we/wdata       : RAM write port
//  peak_valid/pix/bin/count : per-pixel peak result
//  busy, done               : engine active, end-of-frame pulse
module sifh_hist_engine import sifh_pkg::*; #(
  parameter  int unsigned NP        = 10,
  parameter  int unsigned BIN_SHIFT = 0,
  parameter  int unsigned PIXELS    = 4,
  parameter  int unsigned PEAK_W    = 8,
  parameter  int unsigned ACQ_NUM   = 1024,
  localparam int unsigned BIN_W     = NP - BIN_SHIFT,
  localparam int unsigned PIX_W     = pix_w(PIXELS),
  localparam int unsigned ADDR_W    = PIX_W + BIN_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              laser_sync,
  input  logic              ts_valid,
  output logic              ts_ready,
  input  logic [NP-1:0]     ts_data,
  input  logic [PIX_W-1:0]  ts_pix,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_re,
  input  logic [PEAK_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_we,
  output logic [PEAK_W-1:0] ram_wdata,
  output logic              peak_valid,
  output logic [PIX_W-1:0]  peak_pix,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [PEAK_W-1:0] peak_count,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SYNC_W = clog2(ACQ_NUM) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((PIXELS << BIN_W) - 1);
  localparam logic [BIN_W-1:0]  LAST_BIN  = '1;
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(PIXELS - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(ACQ_NUM - 1);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic              scan_done;
  logic              start_go;
  logic              accept;

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [PEAK_W-1:0] s1_old;
  logic [PEAK_W-1:0] s1_wdata;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [PEAK_W-1:0] fwd_data;

  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;

  assign start_go = (state == ST_IDLE) && start;
  assign accept   = (state == ST_ACQ) && ts_valid && (32'(ts_pix) < PIXELS);

  // State register
  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: if (cnt == LAST_ADDR) state_nxt = ST_ACQ;
      ST_ACQ:   if (laser_sync && (sync_cnt == SYNC_LAST)) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_PEAK;
      // Leave only once the last pixel's result has actually been published.
      ST_PEAK:  if (peak_valid && (peak_pix == LAST_PIX)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ts_ready  = 1'b0;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    ram_re    = 1'b0;
    ram_raddr = '0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt;
      end
      ST_ACQ:   ts_ready = 1'b1;
      ST_PEAK: begin
        ram_re    = !scan_done;
        ram_raddr = cnt;
      end
      default: ;
    endcase
    if (accept) begin
      ram_re    = 1'b1;
      ram_raddr = {ts_pix, ts_data[NP-1:BIN_SHIFT]};
    end
    if (s1_valid) begin
      ram_we    = 1'b1;
      ram_waddr = s1_addr;
      ram_wdata = s1_wdata;
    end
  end

  // Clear/scan address counter, sync counter and scan-complete flag
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt       <= '0;
      sync_cnt  <= '0;
      scan_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          cnt       <= '0;
          sync_cnt  <= '0;
          scan_done <= 1'b0;
        end
        ST_CLEAR: cnt <= (cnt == LAST_ADDR) ? '0 : cnt + 1'b1;
        ST_ACQ:   if (laser_sync) sync_cnt <= sync_cnt + 1'b1;
        ST_PEAK:  if (!scan_done) begin
          if (cnt == LAST_ADDR) scan_done <= 1'b1;
          else                  cnt       <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The RAM is read-first, so a hit on the address written in the previous
  // cycle reads stale data; take the value just written instead.
  always_comb begin
    s1_old   = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_data : ram_rdata;
    s1_wdata = PEAK_W'(sat_inc(32'(s1_old), PEAK_W));
  end

  // RMW pipeline and peak-scan read tracking
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
    end else begin
      s1_valid  <= accept;
      s1_addr   <= {ts_pix, ts_data[NP-1:BIN_SHIFT]};
      fwd_valid <= s1_valid;
      fwd_addr  <= s1_addr;
      fwd_data  <= s1_wdata;
      rd_valid  <= (state == ST_PEAK) && !scan_done;
      rd_addr   <= cnt;
    end
  end

  sifh_peak_tracker #(
    .BIN_W (BIN_W),
    .PIX_W (PIX_W),
    .PEAK_W(PEAK_W)
  ) u_tracker (
    .clk       (clk),
    .res       (res),
    .clear     (start_go),
    .sample    (rd_valid),
    .emit      (rd_valid && (rd_addr[BIN_W-1:0] == LAST_BIN)),
    .data      (ram_rdata),
    .bin       (rd_addr[BIN_W-1:0]),
    .pix       (rd_addr[ADDR_W-1:BIN_W]),
    .peak_valid(peak_valid),
    .peak_pix  (peak_pix),
    .peak_bin  (peak_bin),
    .peak_count(peak_count)
  );

endmodule

// File: tb/tb_sifh_hist_engine.sv
module tb_sifh_hist_engine;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       start = 1'b0;
  logic       laser_sync = 1'b0;
  logic       ts_valid = 1'b0;
  logic       ts_ready;
  logic [3:0] ts_data = '0;
  logic [0:0] ts_pix = '0;
  logic [4:0] ram_raddr;
  logic       ram_re;
  logic [3:0] ram_rdata = '0;
  logic [4:0] ram_waddr;
  logic       ram_we;
  logic [3:0] ram_wdata;
  logic       peak_valid;
  logic [0:0] peak_pix;
  logic [3:0] peak_bin;
  logic [3:0] peak_count;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  // Stale contents so that a missing clear shows up in the peak results.
  logic [3:0] mem [32] = '{default: 4'hA};

  always #5 clk = ~clk;

  // Read-first 1R1W RAM model
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  sifh_hist_engine #(
    .NP       (4),
    .BIN_SHIFT(0),
    .PIXELS   (2),
    .PEAK_W   (4),
    .ACQ_NUM  (3)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .laser_sync(laser_sync),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .ts_data   (ts_data),
    .ts_pix    (ts_pix),
    .ram_raddr (ram_raddr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .peak_valid(peak_valid),
    .peak_pix  (peak_pix),
    .peak_bin  (peak_bin),
    .peak_count(peak_count),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b0;
    repeat (2) tick();
    checks++;
    if ({ts_ready, ram_raddr, ram_re, ram_waddr, ram_we, ram_wdata, peak_valid,
         peak_pix, peak_bin, peak_count, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b re=%b we=%b pv=%b busy=%b done=%b peak=%0d/%0d/%0d, want all 0",
               ts_ready, ram_re, ram_we, peak_valid, busy, done, peak_pix, peak_bin, peak_count);
    end
    res = 1'b1;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || ts_ready !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: got busy=%b ready=%b we=%b, want 0 0 0", busy, ts_ready, ram_we);
    end
  endtask

  task automatic test_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (ram_we !== 1'b1 || ram_waddr !== 5'(i) || ram_wdata !== 4'd0 || ts_ready !== 1'b0) begin
        failures++;
        $display("FAIL clear_write[%0d]: got we=%b addr=%0d data=%0d ready=%b, want 1 %0d 0 0",
                 i, ram_we, ram_waddr, ram_wdata, ts_ready, i);
      end
      tick();
    end
    checks++;
    if (ts_ready !== 1'b1 || busy !== 1'b1 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL clear_to_acq: got ready=%b busy=%b we=%b, want 1 1 0", ts_ready, busy, ram_we);
    end
  endtask

  task automatic test_back_to_back();
    ts_valid = 1'b1;
    ts_pix   = 1'b0;
    ts_data  = 4'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) ts_valid = 1'b0;
      checks++;
      if (ram_we !== 1'b1 || ram_waddr !== 5'd7 || ram_wdata !== 4'(i + 1)) begin
        failures++;
        $display("FAIL b2b_write[%0d]: got we=%b addr=%0d data=%0d, want 1 7 %0d",
                 i, ram_we, ram_waddr, ram_wdata, i + 1);
      end
    end
    tick();
    checks++;
    if (ram_we !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got we=%b, want 0", ram_we);
    end
  endtask

  task automatic test_saturation();
    int exp_v;
    ts_valid = 1'b1;
    ts_pix   = 1'b1;
    ts_data  = 4'd3;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 19) ts_valid = 1'b0;
      exp_v = (i + 1 > 15) ? 15 : i + 1;
      checks++;
      if (ram_we !== 1'b1 || ram_waddr !== 5'd19 || ram_wdata !== 4'(exp_v)) begin
        failures++;
        $display("FAIL sat_write[%0d]: got we=%b addr=%0d data=%0d, want 1 19 %0d",
                 i, ram_we, ram_waddr, ram_wdata, exp_v);
      end
    end
    tick();
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (ts_ready !== 1'b1 || ram_we !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_busy: got ready=%b we=%b busy=%b, want 1 0 1", ts_ready, ram_we, busy);
    end
  endtask

  task automatic test_syncs();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ts_ready !== 1'b1) begin
        failures++;
        $display("FAIL sync_acq[%0d]: got ready=%b, want 1", i, ts_ready);
      end
      laser_sync = 1'b1;
      tick();
      laser_sync = 1'b0;
      if (i < 2) tick();
    end
    checks++;
    if (ts_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL sync_end: got ready=%b busy=%b, want 0 1", ts_ready, busy);
    end
  endtask

  // Alternating bin 2 / bin 9 hits; the last hit shares its cycle with the
  // final laser sync and must still be counted.
  task automatic test_tie();
    ts_valid = 1'b1;
    ts_pix   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ts_data    = (i % 2 == 1) ? 4'd9 : 4'd2;
      laser_sync = (i == 1 || i == 3 || i == 7);
      tick();
      checks++;
      if (ram_we !== 1'b1 || ram_waddr !== ((i % 2 == 1) ? 5'd9 : 5'd2) || ram_wdata !== 4'(i / 2 + 1)) begin
        failures++;
        $display("FAIL tie_write[%0d]: got we=%b addr=%0d data=%0d, want 1 %0d %0d",
                 i, ram_we, ram_waddr, ram_wdata, (i % 2 == 1) ? 9 : 2, i / 2 + 1);
      end
    end
    ts_valid   = 1'b0;
    laser_sync = 1'b0;
    checks++;
    if (ts_ready !== 1'b0) begin
      failures++;
      $display("FAIL tie_final_sync: got ready=%b, want 0", ts_ready);
    end
  endtask

  task automatic test_peak(input logic [3:0] bin0, input logic [3:0] cnt0,
                           input logic [3:0] bin1, input logic [3:0] cnt1);
    int n;
    int nd;
    logic [3:0] eb;
    logic [3:0] ec;
    n  = 0;
    nd = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (peak_valid === 1'b1) begin
        eb = (n == 0) ? bin0 : bin1;
        ec = (n == 0) ? cnt0 : cnt1;
        checks++;
        if (peak_pix !== 1'(n) || peak_bin !== eb || peak_count !== ec || nd != 0) begin
          failures++;
          $display("FAIL peak_result[%0d]: got pix=%0d bin=%0d count=%0d, want %0d %0d %0d (before done)",
                   n, peak_pix, peak_bin, peak_count, n, eb, ec);
        end
        n++;
      end
      if (done === 1'b1) nd++;
      if (nd > 0 && busy === 1'b0) break;
    end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL peak_count_pulses: got %0d, want 2", n);
    end
    checks++;
    if (nd != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: got %0d pulses busy=%b, want 1 pulse busy=0", nd, busy);
    end
  endtask

  task automatic test_reset_in_peak();
    test_clear();
    test_syncs();
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1 || ram_re !== 1'b1 || ts_ready !== 1'b0) begin
      failures++;
      $display("FAIL in_peak: got busy=%b re=%b ready=%b, want 1 1 0", busy, ram_re, ts_ready);
    end
    res = 1'b0;
    #1;
    checks++;
    if ({ts_ready, ram_raddr, ram_re, ram_waddr, ram_we, ram_wdata, peak_valid,
         peak_pix, peak_bin, peak_count, busy, done} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got ready=%b re=%b we=%b pv=%b busy=%b done=%b peak=%0d/%0d/%0d, want all 0",
               ts_ready, ram_re, ram_we, peak_valid, busy, done, peak_pix, peak_bin, peak_count);
    end
    tick();
    res = 1'b1;
    tick();
    test_clear();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_back_to_back();
    test_saturation();
    test_start_ignored();
    test_syncs();
    test_peak(4'd7, 4'd5, 4'd3, 4'd15);
    test_clear();
    test_tie();
    test_peak(4'd2, 4'd4, 4'd0, 4'd0);
    test_reset_in_peak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
